// File: rtl/syst_pkg.sv
// Shared types and constants for the systolic-array operand sequencer.
package syst_pkg;

  localparam int DEF_N  = 4;
  localparam int DEF_DW = 16;

  // Buffer selector values carried on ld_sel.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  // Number of skewed feed cycles needed to push an NxN pair through the array edges.
  function automatic int feed_len(input int n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/syst_array_seq_if.sv
// Host/load side and array-edge side of the sequencer, bundled as one interface.
// The address field carries one spare code so an index of N*N can be expressed and dropped.
interface syst_array_seq_if
  import syst_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW
);

  localparam int AW = $clog2(N * N + 1);

  logic          ld_valid;
  logic          ld_ready;
  logic          ld_sel;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          start;
  logic          busy;
  logic          done;
  logic          arr_rst;
  logic [N*DW-1:0] west_data;
  logic [N*DW-1:0] north_data;

  modport master (
    output ld_valid, ld_sel, ld_addr, ld_data, start,
    input  ld_ready, busy, done, arr_rst, west_data, north_data
  );

  modport slave (
    input  ld_valid, ld_sel, ld_addr, ld_data, start,
    output ld_ready, busy, done, arr_rst, west_data, north_data
  );

endinterface

// File: rtl/syst_skew_buf.sv
// NxN operand register file with one write port and a diagonally skewed N-lane read.
// TRANSPOSE=0 reads lane i = [i][t-i] (A rows); TRANSPOSE=1 reads lane j = [t-j][j] (B columns).
module syst_skew_buf #(
  parameter int N         = 4,
  parameter int DW        = 16,
  parameter int AW        = 5,
  parameter int TW        = 4,
  parameter bit TRANSPOSE = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [TW-1:0]   t,
  output logic [N*DW-1:0] lanes
);

  localparam int IW = $clog2(N * N);

  logic [DW-1:0] mem [N*N];

  // Storage: cleared on reset, written row-major; indices past the matrix are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (wr_en && (wr_addr < AW'(N * N))) begin
      mem[wr_addr[IW-1:0]] <= wr_data;
    end
  end

  // Skewed read: lane k sees the element on anti-diagonal t, or zero outside the matrix.
  always_comb begin
    lanes = '0;
    for (int k = 0; k < N; k++) begin
      if ((int'(t) >= k) && ((int'(t) - k) < N)) begin
        if (TRANSPOSE) begin
          lanes[k*DW +: DW] = mem[IW'((int'(t) - k) * N + k)];
        end else begin
          lanes[k*DW +: DW] = mem[IW'(k * N + int'(t) - k)];
        end
      end
    end
  end

endmodule

// File: rtl/syst_array_seq.sv
// Sequencer for the NxN output-stationary systolic array: loads A/B, clears the PEs,
// streams skewed operands into the west/north edges, drains, and pulses done.
// All array-facing outputs are registered from the next-state so they are glitch-free.
module syst_array_seq
  import syst_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int DW        = DEF_DW,
  parameter int DRAIN_CYC = 1
) (
  input logic             clk,
  input logic             rst_n,
  syst_array_seq_if.slave bus
);

  localparam int AW = $clog2(N * N + 1);
  localparam int CW = $clog2(3 * N + DRAIN_CYC);
  localparam logic [CW-1:0] FEED_LAST  = CW'(feed_len(N) - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          wr_en;
  logic [N*DW-1:0] west_lanes;
  logic [N*DW-1:0] north_lanes;

  // Loads are only accepted while idle so the buffers stay stable during a run.
  assign bus.ld_ready = (state == IDLE);
  assign wr_en        = bus.ld_valid && (state == IDLE);

  // The buffers are read at the upcoming feed index so the output registers line up with it.
  syst_skew_buf #(
    .N(N), .DW(DW), .AW(AW), .TW(CW), .TRANSPOSE(1'b0)
  ) u_buf_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en && (bus.ld_sel == SEL_A)),
    .wr_addr (bus.ld_addr),
    .wr_data (bus.ld_data),
    .t       (cnt_nxt),
    .lanes   (west_lanes)
  );

  syst_skew_buf #(
    .N(N), .DW(DW), .AW(AW), .TW(CW), .TRANSPOSE(1'b1)
  ) u_buf_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en && (bus.ld_sel == SEL_B)),
    .wr_addr (bus.ld_addr),
    .wr_data (bus.ld_data),
    .t       (cnt_nxt),
    .lanes   (north_lanes)
  );

  // State and feed/drain counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: one clear cycle, the skewed feed, optional drain, one done cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        state_nxt = FEED;
        cnt_nxt   = '0;
      end
      FEED: begin
        if (cnt == FEED_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (DRAIN_CYC > 0) ? DRAIN : DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Registered array-facing outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.arr_rst    <= 1'b1;
      bus.west_data  <= '0;
      bus.north_data <= '0;
    end else begin
      bus.busy       <= (state_nxt != IDLE);
      bus.done       <= (state_nxt == DONE);
      bus.arr_rst    <= (state_nxt == CLEAR);
      bus.west_data  <= (state_nxt == FEED) ? west_lanes  : '0;
      bus.north_data <= (state_nxt == FEED) ? north_lanes : '0;
    end
  end

endmodule

// File: tb/tb_syst_array_seq.sv
// Self-checking bench for syst_array_seq (N=4, DW=16, DRAIN_CYC=1).
// Expected feeds come from plain matrix arrays: row i of A enters row i delayed by i cycles,
// column j of B enters column j delayed by j cycles.
module tb_syst_array_seq;
  import syst_pkg::*;

  localparam int N         = 4;
  localparam int DW        = 16;
  localparam int DRAIN_CYC = 1;
  localparam int AW        = $clog2(N * N + 1);
  localparam int FEEDS     = 3 * N - 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  int a_mod [N][N];
  int b_mod [N][N];

  syst_array_seq_if #(.N(N), .DW(DW)) bus ();

  syst_array_seq #(.N(N), .DW(DW), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic sel, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic st);
    bus.ld_valid = v;
    bus.ld_sel   = sel;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    bus.start    = st;
    tick;
    bus.ld_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic model_write(input logic sel, input int addr, input int data);
    if (addr < N * N) begin
      if (sel == SEL_A) a_mod[addr / N][addr % N] = data;
      else              b_mod[addr / N][addr % N] = data;
    end
  endtask

  task automatic model_clear;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a_mod[r][c] = 0;
        b_mod[r][c] = 0;
      end
  endtask

  task automatic load(input logic sel, input int addr, input int data, input logic st);
    applyStimulus(1'b1, sel, AW'(addr), DW'(data), st);
    model_write(sel, addr, data);
  endtask

  function automatic logic [63:0] exp_west(input int t);
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      if (t - r >= 0 && t - r < N) v[r*DW +: DW] = DW'(a_mod[r][t-r]);
    return v;
  endfunction

  function automatic logic [63:0] exp_north(input int t);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < N; c++)
      if (t - c >= 0 && t - c < N) v[c*DW +: DW] = DW'(b_mod[t-c][c]);
    return v;
  endfunction

  // Called right after the edge that sampled start. mode 0: plain run,
  // mode 1: start/load attempts while busy, mode 2: reset abort at t=5.
  task automatic check_run(input string tag, input int mode);
    checkBit({tag, ".clr_arr_rst"}, bus.arr_rst, 1'b1);
    checkBit({tag, ".clr_busy"}, bus.busy, 1'b1);
    checkBit({tag, ".clr_done"}, bus.done, 1'b0);
    checkBit({tag, ".clr_ld_ready"}, bus.ld_ready, 1'b0);
    checkOutput({tag, ".clr_west"}, bus.west_data, 64'd0);
    for (int t = 0; t < FEEDS; t++) begin
      tick;
      checkOutput($sformatf("%s.west_t%0d", tag, t), bus.west_data, exp_west(t));
      checkOutput($sformatf("%s.north_t%0d", tag, t), bus.north_data, exp_north(t));
      checkBit($sformatf("%s.arr_rst_t%0d", tag, t), bus.arr_rst, 1'b0);
      checkBit($sformatf("%s.busy_t%0d", tag, t), bus.busy, 1'b1);
      checkBit($sformatf("%s.done_t%0d", tag, t), bus.done, 1'b0);
      if (mode == 1) begin
        checkBit($sformatf("%s.ld_ready_t%0d", tag, t), bus.ld_ready, 1'b0);
        if (t == 4) bus.start = 1'b1;
        if (t == 5) begin
          bus.start    = 1'b0;
          bus.ld_valid = 1'b1;
          bus.ld_sel   = SEL_A;
          bus.ld_addr  = '0;
          bus.ld_data  = 16'hFFFF;
        end
        if (t == 6) bus.ld_valid = 1'b0;
      end
      if (mode == 2 && t == 5) begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput({tag, ".abort_west"}, bus.west_data, 64'd0);
        checkOutput({tag, ".abort_north"}, bus.north_data, 64'd0);
        checkBit({tag, ".abort_arr_rst"}, bus.arr_rst, 1'b1);
        checkBit({tag, ".abort_busy"}, bus.busy, 1'b0);
        checkBit({tag, ".abort_done"}, bus.done, 1'b0);
        repeat (3) begin
          tick;
          checkBit({tag, ".abort_hold_done"}, bus.done, 1'b0);
        end
        rst_n = 1'b1;
        repeat (12) begin
          tick;
          checkBit({tag, ".post_done"}, bus.done, 1'b0);
          checkBit({tag, ".post_busy"}, bus.busy, 1'b0);
        end
        model_clear();
        return;
      end
    end
    for (int d = 0; d < DRAIN_CYC; d++) begin
      tick;
      checkOutput({tag, ".drain_west"}, bus.west_data, 64'd0);
      checkOutput({tag, ".drain_north"}, bus.north_data, 64'd0);
      checkBit({tag, ".drain_busy"}, bus.busy, 1'b1);
      checkBit({tag, ".drain_done"}, bus.done, 1'b0);
    end
    tick;
    checkBit({tag, ".done_pulse"}, bus.done, 1'b1);
    checkBit({tag, ".done_busy"}, bus.busy, 1'b1);
    tick;
    checkBit({tag, ".idle_done"}, bus.done, 1'b0);
    checkBit({tag, ".idle_busy"}, bus.busy, 1'b0);
    checkBit({tag, ".idle_ld_ready"}, bus.ld_ready, 1'b1);
    checkBit({tag, ".idle_arr_rst"}, bus.arr_rst, 1'b0);
  endtask

  initial begin
    bus.ld_valid = 1'b0;
    bus.ld_sel   = SEL_A;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    bus.start    = 1'b0;
    model_clear();

    // Reset values while held in reset.
    #12;
    checkBit("rst_busy", bus.busy, 1'b0);
    checkBit("rst_done", bus.done, 1'b0);
    checkBit("rst_arr_rst", bus.arr_rst, 1'b1);
    checkBit("rst_ld_ready", bus.ld_ready, 1'b1);
    checkOutput("rst_west", bus.west_data, 64'd0);
    checkOutput("rst_north", bus.north_data, 64'd0);
    rst_n = 1'b1;
    tick;
    checkBit("idle_arr_rst", bus.arr_rst, 1'b0);
    checkBit("idle_ld_ready", bus.ld_ready, 1'b1);

    // Directed operands: A[i][k]=10i+k+1, B[k][j]=100k+j.
    $display("[TB] directed load and feed");
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        load(SEL_A, r * N + c, 10 * r + c + 1, 1'b0);
        load(SEL_B, r * N + c, 100 * r + c, 1'b0);
      end

    // Out-of-range writes must leave both buffers untouched.
    applyStimulus(1'b1, SEL_A, AW'(16), 16'hBEEF, 1'b0);
    applyStimulus(1'b1, SEL_B, AW'(16), 16'hBEEF, 1'b0);

    applyStimulus(1'b0, SEL_A, '0, '0, 1'b1);
    check_run("run1", 0);

    $display("[TB] start/load ignored while busy");
    applyStimulus(1'b0, SEL_A, '0, '0, 1'b1);
    check_run("busy_ign", 1);
    applyStimulus(1'b0, SEL_A, '0, '0, 1'b1);
    check_run("rerun", 0);

    $display("[TB] simultaneous load and start");
    load(SEL_A, 0, 16'h00AA, 1'b1);
    check_run("simul", 0);

    $display("[TB] reset abort mid-feed");
    applyStimulus(1'b0, SEL_A, '0, '0, 1'b1);
    check_run("abort", 2);
    for (int w = 0; w < 4; w++)
      load(logic'($urandom_range(0, 1)), $urandom_range(0, N * N - 1), $urandom_range(0, 16'hFFFF), 1'b0);
    load(SEL_B, 5, $urandom_range(1, 16'hFFFF), 1'b1);
    check_run("post_abort", 0);

    $display("[TB] randomized operands");
    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          load(SEL_A, r * N + c, $urandom_range(0, 16'hFFFF), 1'b0);
          load(SEL_B, r * N + c, $urandom_range(0, 16'hFFFF), 1'b0);
        end
      applyStimulus(1'b1, logic'($urandom_range(0, 1)), AW'($urandom_range(N * N, 2 * N * N - 1)),
                    DW'($urandom_range(0, 16'hFFFF)), 1'b0);
      applyStimulus(1'b0, SEL_A, '0, '0, 1'b1);
      check_run($sformatf("rand%0d", it), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
